fetch_stage: RTL
================

FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000: PC value loaded on reset.
REQ-002 SHALL have parameter NOP_WORD, default 32'h0000_0000: instruction word inserted on a bubble.
REQ-003 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset, input, 1, asynchronous active-high reset.
REQ-005 SHALL have port stall, input, 1, hazard stall from decode; holds PC and the IF/ID register.
REQ-006 SHALL have port flush, input, 1, squashes the instruction entering IF/ID.
REQ-007 SHALL have port branch_taken, input, 1, redirect request from a later stage.
REQ-008 SHALL have port branch_target, input, 32, redirect byte address.
REQ-009 SHALL have port imem_addr, output, 32, byte address to the instruction ROM.
REQ-010 SHALL have port imem_data, input, 32, instruction word returned combinationally by the ROM.
REQ-011 SHALL have port if_id_instr, output, 32, registered instruction to decode.
REQ-012 SHALL have port if_id_pc, output, 32, registered address of if_id_instr.
REQ-013 SHALL have port if_id_pc_plus4, output, 32, registered if_id_pc + 4.
REQ-014 SHALL have port if_id_valid, output, 1, high when if_id_instr is a real fetched instruction.
REQ-015 SHALL have port fetch_count, output, 32, number of valid instructions delivered to IF/ID.

Function
REQ-016 SHALL hold a 32-bit PC register; imem_addr SHALL equal PC combinationally, with no added latency.
REQ-017 SHALL keep PC[1:0] at 2'b00 at all times; branch_target[1:0] SHALL be ignored and replaced by 2'b00.
REQ-018 SHALL choose next PC by priority: branch_taken -> {branch_target[31:2],2'b00}; else stall -> hold PC; else PC+4.
REQ-019 SHALL compute PC+4 modulo 2^32, so 32'hFFFF_FFFC advances to 32'h0000_0000 without error.
REQ-020 SHALL update IF/ID by priority: branch_taken or flush -> bubble; else stall -> hold all IF/ID fields and fetch_count; else load.
REQ-021 Bubble SHALL mean if_id_instr=NOP_WORD, if_id_valid=0, and if_id_pc/if_id_pc_plus4 loaded from the current PC and PC+4.
REQ-022 Load SHALL mean if_id_instr=imem_data, if_id_pc=PC, if_id_pc_plus4=PC+4, if_id_valid=1, and fetch_count+1.
REQ-023 SHALL give fetch latency of one cycle: the word at imem_addr in cycle N appears on if_id_instr after edge N+1.
REQ-024 When branch_taken and stall are high together, SHALL redirect PC and bubble IF/ID; the redirect overrides the stall.
REQ-025 When flush is high and branch_taken is low, SHALL advance PC per REQ-018 while still bubbling IF/ID.
REQ-026 SHALL let fetch_count wrap from 32'hFFFF_FFFF to 0, and SHALL NOT increment it on a bubble or a stall.
REQ-027 SHALL treat X on imem_data as data and pass it through unchanged; no checking of the value.

Reset
REQ-028 While reset is high, asynchronously and independent of clk: PC=RESET_PC, if_id_instr=NOP_WORD, if_id_pc=RESET_PC, if_id_pc_plus4=RESET_PC+4, if_id_valid=0, fetch_count=0.
REQ-029 A reset asserted mid-operation SHALL discard any pending stall, flush or branch with no residual effect.
REQ-030 On the first rising edge after reset deasserts, with no stall, flush or branch, SHALL load the word at RESET_PC with if_id_valid=1.

Verification
REQ-031 Reset, then 4 idle cycles with the ROM returning word = address -> imem_addr steps 0,4,8,12; if_id_instr 0,4,8 lags by one cycle; fetch_count=4 after the 4th edge.
REQ-032 Stall held 3 cycles at PC=8 -> imem_addr stays 8; IF/ID fields and fetch_count frozen; PC resumes at 12 after release.
REQ-033 branch_taken=1 with branch_target=32'h0000_0043 and stall=1 at the same edge -> PC=32'h40; if_id_valid=0, if_id_instr=NOP_WORD; next edge loads the word at 0x40.
REQ-034 flush=1 alone at PC=16 -> if_id_valid=0, PC=20, fetch_count unchanged.
REQ-035 Preload PC=32'hFFFF_FFFC via a branch, then 1 idle cycle -> PC=0 and if_id_pc=32'hFFFF_FFFC.
REQ-036 Assert reset between clock edges during a stall -> all outputs take their REQ-028 values immediately, before the next edge.

Source files
------------

// File: rtl/fetch_stage.sv
// Instruction fetch stage: PC register, next-PC selection and the IF/ID pipeline register.
// Latency: one cycle from imem_addr to if_id_instr; stall holds PC and IF/ID, while a redirect or flush inserts a bubble.
module fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_WORD = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        flush,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_data,
  output logic [31:0] if_id_instr,
  output logic [31:0] if_id_pc,
  output logic [31:0] if_id_pc_plus4,
  output logic        if_id_valid,
  output logic [31:0] fetch_count
);

  // The PC stays word aligned, including straight out of reset.
  localparam logic [31:0] RESET_PC_ALIGNED = {RESET_PC[31:2], 2'b00};

  logic [31:0] pc_q, pc_d;
  logic [31:0] pc_plus4;
  logic [31:0] instr_q, instr_d;
  logic [31:0] id_pc_q, id_pc_d;
  logic [31:0] id_pc4_q, id_pc4_d;
  logic        valid_q, valid_d;
  logic [31:0] count_q, count_d;

  assign pc_plus4 = pc_q + 32'd4;

  always_comb begin
    pc_d = pc_q;
    if (branch_taken) begin
      pc_d = {branch_target[31:2], 2'b00};
    end else if (!stall) begin
      pc_d = pc_plus4;
    end
  end

  // A redirect or flush squashes the word entering IF/ID even when decode is stalled.
  always_comb begin
    instr_d  = instr_q;
    id_pc_d  = id_pc_q;
    id_pc4_d = id_pc4_q;
    valid_d  = valid_q;
    count_d  = count_q;
    if (branch_taken || flush) begin
      instr_d  = NOP_WORD;
      id_pc_d  = pc_q;
      id_pc4_d = pc_plus4;
      valid_d  = 1'b0;
    end else if (!stall) begin
      instr_d  = imem_data;
      id_pc_d  = pc_q;
      id_pc4_d = pc_plus4;
      valid_d  = 1'b1;
      count_d  = count_q + 32'd1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_q     <= RESET_PC_ALIGNED;
      instr_q  <= NOP_WORD;
      id_pc_q  <= RESET_PC_ALIGNED;
      id_pc4_q <= RESET_PC_ALIGNED + 32'd4;
      valid_q  <= 1'b0;
      count_q  <= 32'd0;
    end else begin
      pc_q     <= pc_d;
      instr_q  <= instr_d;
      id_pc_q  <= id_pc_d;
      id_pc4_q <= id_pc4_d;
      valid_q  <= valid_d;
      count_q  <= count_d;
    end
  end

  assign imem_addr      = pc_q;
  assign if_id_instr    = instr_q;
  assign if_id_pc       = id_pc_q;
  assign if_id_pc_plus4 = id_pc4_q;
  assign if_id_valid    = valid_q;
  assign fetch_count    = count_q;

endmodule
